branch_predict_unit: RTL
========================

# branch_predict_unit

Parametrised branch prediction and resolution unit for the 5-stage RISC-V pipeline. In IF it supplies a taken/target prediction from a direct-mapped BTB with 2-bit saturating counters. In EX it resolves the actual outcome of all six conditional-branch types plus JAL/JALR and raises a redirect on misprediction. It then trains the tables and keeps saturating performance counters. It replaces fixed predict-not-taken next-PC selection. Write-back muxing remains outside this block.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- IDX_W, 6, BTB index bits; entry count = 2**IDX_W
- TAG_W, 8, stored tag bits
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock; one clock domain, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  XLEN  PC being fetched
- if_pred_taken  out  1  prediction for if_pc
- if_pred_target  out  XLEN  predicted target; if_pc+4 when if_pred_taken=0
- ex_valid  in  1  EX holds a live instruction (already qualified by stall/flush)
- ex_branch  in  1  conditional branch
- ex_jump  in  1  JAL or JALR
- ex_func3  in  3  branch funct3
- ex_zero  in  1  rs1==rs2
- ex_lt  in  1  signed rs1<rs2
- ex_ltu  in  1  unsigned rs1<rs2
- ex_pc  in  XLEN  PC of EX instruction
- ex_target  in  XLEN  computed target (branch/JAL: pc+imm; JALR: (rs1+imm)&~1)
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- ex_pred_target  in  XLEN  predicted target carried down the pipe
- ex_taken  out  1  resolved taken
- redirect  out  1  mispredict; flush IF/ID and load redirect_pc
- redirect_pc  out  XLEN  corrected fetch PC
- perf_branches  out  CNT_W  resolved control-transfer count
- perf_mispredicts  out  CNT_W  redirect count

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Each entry holds valid, tag, target, and a 2-bit counter.
- Lookup is combinational from registered tables. A hit is valid && tag match.
- if_pred_taken = hit && ctr[1]. if_pred_target = stored target on a predicted-taken hit, else if_pc+4.
- Resolution, applied only when ex_valid:
  - jump: taken.
  - branch, funct3 000/001: zero / ~zero.
  - branch, funct3 100/101: lt / ~lt.
  - branch, funct3 110/111: ltu / ~ltu.
  - branch, funct3 010/011: not taken, and no table update.
  - otherwise: not taken.
- Redirect, evaluated only when ex_valid:
  - ex_taken && (!ex_pred_taken || ex_pred_target != ex_target): redirect_pc = ex_target.
  - !ex_taken && ex_pred_taken: redirect_pc = ex_pc+4. This case includes a non-control instruction that aliased to a predicted-taken entry.
  - Otherwise redirect=0 and redirect_pc = ex_pc+4.
- Training, on the clock edge when ex_valid:
  - Branch hit: counter saturating +1 if taken, -1 if not. If taken, rewrite target.
  - Branch miss and taken: allocate entry (valid=1, tag, target, ctr=2'b10).
  - Branch miss and not taken: no change.
  - Jump: allocate or overwrite with ctr=2'b11 and target=ex_target.
  - Non-control instruction that hits: clear valid.
- Performance counters, saturating at all-ones:
  - perf_branches +1 when ex_valid && (ex_branch || ex_jump), excluding illegal funct3.
  - perf_mispredicts +1 when redirect.

## Timing
- Prediction and resolution are zero-latency combinational outputs. Table writes take effect the cycle after the resolving EX cycle.
- Same-cycle lookup and update of the same index returns the pre-update entry. There is no bypass.
- ex_valid=0: redirect=0, ex_taken=0, no state change.
- Reset values:
  - every valid bit = 0, every counter = 2'b01, targets/tags = 0
  - perf counters = 0
  - if_pred_taken = 0 and if_pred_target = if_pc+4 (follows from cleared valid bits)
- While rst=1, redirect and ex_taken are forced to 0 and no training occurs. Reset asserted mid-operation discards any in-flight update on that edge.
- Counter saturation: 2'b11 + taken stays at 11; 2'b00 + not-taken stays at 00. Perf counters hold at 2**CNT_W-1.
- PC arithmetic (+4) is modulo 2**XLEN; wrap is not flagged.

## Test plan
- After reset, if_pc=0x100 -> pred_taken=0 and target=0x104. BEQ at 0x100, zero=1, target 0x80, pred 0 -> redirect=1, redirect_pc=0x80. Next cycle lookup 0x100 -> taken, target 0x80.
- Same BEQ trained four times taken, then resolved not taken four times -> counter 11→10→01→00. Prediction flips to not-taken after the second not-taken. The not-taken mispredicts redirect to 0x104.
- BLTU (110) with lt=1, ltu=0, and BGE (101) with lt=0, zero=1 -> BLTU not taken; BGE taken.
- JALR at 0x200 predicted to 0x300, actual 0x340 -> redirect_pc=0x340. Entry target updated to 0x340 with ctr=11.
- Two PCs aliasing one index with different tags: the second allocates and evicts the first. An ADD at the aliased PC predicted taken -> redirect to pc+4 and the entry is invalidated.
- rst asserted in the same cycle as a mispredicting ex_valid -> redirect=0, tables and perf counters cleared. CNT_W=4 bench: 20 branches -> perf_branches holds at 15.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: IF-stage prediction, EX-stage branch/jump
// resolution with redirect on mispredict, table training and saturating perf counters.
module branch_predict_unit #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int TAG_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    output logic [XLEN-1:0]  if_pred_target,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [2:0]       ex_func3,
    input  logic             ex_zero,
    input  logic             ex_lt,
    input  logic             ex_ltu,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             ex_taken,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);

    localparam int ENTRIES = 1 << IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
    } btb_entry_t;

    btb_entry_t btb [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    btb_entry_t       if_ent, ex_ent;
    logic             if_hit, ex_hit;
    logic             live, illegal, cond, count_br;
    logic [1:0]       next_ctr;
    logic [XLEN-1:0]  ex_pc_plus4;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_pc_bits = ^{if_pc, ex_pc};

    assign if_ent = btb[if_idx];
    assign ex_ent = btb[ex_idx];
    assign if_hit = if_ent.valid && (if_ent.tag == if_tag);
    assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

    assign if_pred_taken  = if_hit && if_ent.ctr[1];
    assign if_pred_target = if_pred_taken ? if_ent.target : if_pc + XLEN'(4);

    // funct3 010/011 are not branch encodings: resolve not-taken, never train or count
    assign live     = ex_valid && !rst;
    assign illegal  = ex_branch && !ex_jump && (ex_func3[2:1] == 2'b01);
    assign count_br = live && (ex_branch || ex_jump) && !illegal;

    always_comb begin
        cond = 1'b0;
        case (ex_func3)
            3'b000:  cond = ex_zero;
            3'b001:  cond = !ex_zero;
            3'b100:  cond = ex_lt;
            3'b101:  cond = !ex_lt;
            3'b110:  cond = ex_ltu;
            3'b111:  cond = !ex_ltu;
            default: cond = 1'b0;
        endcase
    end

    assign ex_taken    = live && (ex_jump || (ex_branch && cond));
    assign ex_pc_plus4 = ex_pc + XLEN'(4);
    assign redirect    = live && (ex_taken ? (!ex_pred_taken || (ex_pred_target != ex_target))
                                           : ex_pred_taken);
    assign redirect_pc = ex_taken ? ex_target : ex_pc_plus4;

    always_comb begin
        next_ctr = ex_ent.ctr;
        if (ex_taken && ex_ent.ctr != 2'b11)
            next_ctr = ex_ent.ctr + 2'b01;
        else if (!ex_taken && ex_ent.ctr != 2'b00)
            next_ctr = ex_ent.ctr - 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (ex_valid) begin
                if (ex_jump) begin
                    btb[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target, ctr: 2'b11};
                end else if (ex_branch && !illegal) begin
                    if (ex_hit) begin
                        btb[ex_idx].ctr <= next_ctr;
                        if (ex_taken)
                            btb[ex_idx].target <= ex_target;
                    end else if (ex_taken) begin
                        btb[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target, ctr: 2'b10};
                    end
                end else if (!ex_branch && ex_hit) begin
                    // non-control instruction aliased onto a live entry: drop it
                    btb[ex_idx].valid <= 1'b0;
                end
            end
            if (count_br && perf_branches != '1)
                perf_branches <= perf_branches + CNT_W'(1);
            if (redirect && perf_mispredicts != '1)
                perf_mispredicts <= perf_mispredicts + CNT_W'(1);
        end
    end

endmodule
